// File: rtl/sar_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// sar_scan_ctrl_if
//   Bundles every non-clock signal of the SAR conversion scheduler:
//   the channel request/ack lines, the ADC core control/result lines and the
//   tagged result valid/ready stream.
//
//   Ports (signals):
//     req[N_CH]      client -> ctrl  per-channel conversion request (level)
//     ack[N_CH]      ctrl -> client  one-cycle pulse when a result is accepted
//     adc_start      ctrl -> core    one-cycle conversion start pulse
//     adc_ch[CW]     ctrl -> core    analog mux select
//     adc_done       core -> ctrl    conversion complete (level)
//     adc_data[DW]   core -> ctrl    conversion result
//     res_valid      ctrl -> sink    result available
//     res_ready      sink -> ctrl    result accepted
//     res_data[DW]   ctrl -> sink    result value (0 on timeout)
//     res_ch[CW]     ctrl -> sink    channel tag of the result
//     res_err        ctrl -> sink    1 = timeout abort
//     busy           ctrl -> any     scheduler not idle
//
//   Modports:
//     master : the scheduler itself
//     slave  : the surrounding clients, ADC core and result sink
// ----------------------------------------------------------------------------
interface sar_scan_ctrl_if #(
  parameter int N_CH = 4,
  parameter int DW   = 12
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] ack;
  logic            adc_start;
  logic [CW-1:0]   adc_ch;
  logic            adc_done;
  logic [DW-1:0]   adc_data;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [CW-1:0]   res_ch;
  logic            res_err;
  logic            busy;

  modport master (
    input  req, adc_done, adc_data, res_ready,
    output ack, adc_start, adc_ch, res_valid, res_data, res_ch, res_err, busy
  );

  modport slave (
    output req, adc_done, adc_data, res_ready,
    input  ack, adc_start, adc_ch, res_valid, res_data, res_ch, res_err, busy
  );
endinterface

// File: rtl/sar_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sar_scan_ctrl
//   Shares one SAR ADC core between N_CH requesting channels. Pending
//   requests are granted round-robin; each grant pulses the core start,
//   drives the mux select, waits for done (with a timeout) and hands back a
//   channel-tagged result over a valid/ready stream.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    sar_scan_ctrl_if.master (req/ack, adc_*, res_*, busy)
//
//   Optional feature macro: SAR_SCAN_AVG_EN
//     When defined, each grant runs 2^AVG_LOG2 conversions on the same
//     channel and returns the truncated mean. When undefined, one conversion
//     per grant and no accumulator exists.
// ----------------------------------------------------------------------------
module sar_scan_ctrl #(
  parameter int N_CH     = 4,
  parameter int DW       = 12,
  parameter int TMO_CYC  = 64,
  parameter int AVG_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sar_scan_ctrl_if.master bus
);
  localparam int CW = $clog2(N_CH);
  localparam int TW = $clog2(TMO_CYC);

  // Elaboration-time guards on the parameter ranges the logic relies on.
  if (N_CH < 2 || N_CH > 16) begin : g_badNch
    $error("sar_scan_ctrl: N_CH must be 2..16");
  end
  if (TMO_CYC < DW + 2) begin : g_badTmo
    $error("sar_scan_ctrl: TMO_CYC must be >= DW+2");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_badAvg
    $error("sar_scan_ctrl: AVG_LOG2 must be 0..8");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_adcCh;
  logic [CW-1:0]   r_rrPtr;
  logic [TW-1:0]   r_tmoCnt;
  logic [DW-1:0]   r_resData;
  logic            r_resErr;
  logic [CW-1:0]   w_grant;
  logic            w_grantValid;
  logic [CW-1:0]   w_rrNext;
  logic            w_tmoHit;

`ifdef SAR_SCAN_AVG_EN
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = DW + AVG_LOG2;

  logic [PW-1:0]   r_pass;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   w_accSum;
  logic            w_lastPass;

  assign w_accSum   = r_acc + AW'(bus.adc_data);
  assign w_lastPass = (r_pass == PW'((1 << AVG_LOG2) - 1));
`endif

  assign w_tmoHit = (r_tmoCnt == TW'(TMO_CYC - 1));
  assign w_rrNext = (r_adcCh == CW'(N_CH - 1)) ? '0 : r_adcCh + 1'b1;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    w_grantValid = 1'b0;
    w_grant      = r_rrPtr;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_grantValid && bus.req[CW'((int'(r_rrPtr) + i) % N_CH)]) begin
        w_grantValid = 1'b1;
        w_grant      = CW'((int'(r_rrPtr) + i) % N_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state and state-decoded outputs. adc_done beats the timeout when
  // both occur in the same WAIT cycle.
  always_comb begin
    w_nextState   = r_state;
    bus.ack       = '0;
    bus.adc_start = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grantValid) w_nextState = START;
      end
      START: begin
        bus.adc_start = 1'b1;
        w_nextState   = WAIT;
      end
      WAIT: begin
        if (bus.adc_done) begin
`ifdef SAR_SCAN_AVG_EN
          w_nextState = w_lastPass ? OUT : START;
`else
          w_nextState = OUT;
`endif
        end else if (w_tmoHit) begin
          w_nextState = OUT;
        end
      end
      OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          bus.ack     = N_CH'(1) << r_adcCh;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: grant latch, timeout counter, result capture, pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adcCh   <= '0;
      r_rrPtr   <= '0;
      r_tmoCnt  <= '0;
      r_resData <= '0;
      r_resErr  <= 1'b0;
`ifdef SAR_SCAN_AVG_EN
      r_pass    <= '0;
      r_acc     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_adcCh <= w_grant;
`ifdef SAR_SCAN_AVG_EN
            r_pass  <= '0;
            r_acc   <= '0;
`endif
          end
        end
        START: r_tmoCnt <= '0;
        WAIT: begin
          r_tmoCnt <= r_tmoCnt + 1'b1;
          if (bus.adc_done) begin
`ifdef SAR_SCAN_AVG_EN
            r_acc <= w_accSum;
            if (w_lastPass) begin
              r_resData <= DW'(w_accSum >> AVG_LOG2);
              r_resErr  <= 1'b0;
            end else begin
              r_pass <= r_pass + 1'b1;
            end
`else
            r_resData <= bus.adc_data;
            r_resErr  <= 1'b0;
`endif
          end else if (w_tmoHit) begin
            r_resData <= '0;
            r_resErr  <= 1'b1;
          end
        end
        OUT: begin
          if (bus.res_ready) r_rrPtr <= w_rrNext;
        end
        default: ;
      endcase
    end
  end

  assign bus.adc_ch   = r_adcCh;
  assign bus.res_ch   = r_adcCh;
  assign bus.res_data = r_resData;
  assign bus.res_err  = r_resErr;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sar_scan_ctrl
//   Directed bench for sar_scan_ctrl (N_CH=4, DW=12, TMO_CYC=64). A table of
//   single-grant transactions with hand-computed results, followed by
//   round-robin, mid-conversion reset and (with SAR_SCAN_AVG_EN) averaging
//   sequences. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sar_scan_ctrl;
  localparam int N_CH    = 4;
  localparam int DW      = 12;
  localparam int TMO_CYC = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sar_scan_ctrl_if #(.N_CH(N_CH), .DW(DW)) bus ();

  sar_scan_ctrl #(
    .N_CH(N_CH), .DW(DW), .TMO_CYC(TMO_CYC), .AVG_LOG2(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          doneDly;
    logic [11:0] data;
    int          readyDly;
    bit          readyEarly;
    bit          dropReq;
    logic [1:0]  expCh;
    logic [11:0] expData;
    bit          expErr;
    int          expLat;
    logic [3:0]  expAck;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete grant: request, start pulse, core response, result, ack.
  task automatic applyStimulus(input vec_t v);
    bit          got;
    bit          chStable;
    bit          ackEarlyOk;
    bit          holdOk;
    int          lat;
    int          extraStarts;
    logic [1:0]  ch0;
    logic [11:0] d0;
    @(negedge clk);
    bus.req       = v.req;
    bus.res_ready = v.readyEarly;
    got = 0; lat = 0;
    for (int c = 1; c <= 5 && !got; c++) begin
      @(negedge clk);
      if (bus.adc_start) begin got = 1; lat = c; end
    end
    checkOutput("startSeen", got, 1);
    checkOutput("startLat", lat, 1);
    checkOutput("adcCh", bus.adc_ch, v.expCh);
    checkOutput("busyStart", bus.busy, 1);
    if (v.dropReq) bus.req = '0;
    ch0 = bus.adc_ch;
    got = 0; lat = 0; extraStarts = 0; chStable = 1; ackEarlyOk = 1;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      bus.adc_data = ~v.data;
      if (bus.res_valid) begin
        got = 1; lat = c;
      end else begin
        if (bus.adc_start) extraStarts++;
        if (bus.adc_ch !== ch0) chStable = 0;
        if (bus.ack !== 4'b0) ackEarlyOk = 0;
        if (c == v.doneDly) begin
          bus.adc_done = 1'b1;
          bus.adc_data = v.data;
        end
      end
    end
    checkOutput("validSeen", got, 1);
    checkOutput("validLat", lat, v.expLat);
    checkOutput("extraStarts", extraStarts, 0);
    checkOutput("chStable", chStable, 1);
    checkOutput("noEarlyAck", ackEarlyOk, 1);
    checkOutput("resData", bus.res_data, v.expData);
    checkOutput("resCh", bus.res_ch, v.expCh);
    checkOutput("resErr", bus.res_err, v.expErr);
    d0 = bus.res_data;
    holdOk = 1;
    for (int c = 0; c < v.readyDly; c++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== d0 || bus.res_ch !== v.expCh ||
          bus.ack !== 4'b0 || bus.adc_start) holdOk = 0;
    end
    if (v.readyDly > 0) checkOutput("holdStable", holdOk, 1);
    bus.res_ready = 1'b1;
    #1;
    checkOutput("ack", bus.ack, v.expAck);
    bus.req = '0;
    @(negedge clk);
    checkOutput("validDrop", bus.res_valid, 0);
    checkOutput("ackPulse", bus.ack, 0);
    checkOutput("busyIdle", bus.busy, 0);
    bus.res_ready = 1'b0;
  endtask

  // Five grants with all requests held high; pointer starts at 0.
  task automatic runRoundRobin();
    bit got;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      got = 0;
      for (int c = 1; c <= 10 && !got; c++) begin
        @(negedge clk);
        if (bus.adc_start) got = 1;
      end
      checkOutput("rrStartSeen", got, 1);
      checkOutput("rrGrant", bus.adc_ch, g % 4);
      got = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
        @(negedge clk);
        bus.adc_done = 1'b0;
        if (bus.res_valid) got = 1;
        else if (c == 2) begin
          bus.adc_done = 1'b1;
          bus.adc_data = 12'(g * 16 + 1);
        end
      end
      checkOutput("rrValid", got, 1);
      checkOutput("rrData", bus.res_data, g * 16 + 1);
      checkOutput("rrAck", bus.ack, 4'b0001 << (g % 4));
      if (g == 4) bus.req = '0;
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // Reset during WAIT, then a fresh grant that must come from pointer 0.
  task automatic runResetMidWait();
    bit got;
    @(negedge clk);
    bus.req = 4'b0010;
    got = 0;
    for (int c = 1; c <= 5 && !got; c++) begin
      @(negedge clk);
      if (bus.adc_start) got = 1;
    end
    checkOutput("rstPreStart", got, 1);
    repeat (3) @(negedge clk);
    checkOutput("rstPreBusy", bus.busy, 1);
    rst_n         = 1'b0;
    bus.req       = 4'b0011;
    bus.res_ready = 1'b1;
    #1;
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstValid", bus.res_valid, 0);
    checkOutput("rstStart", bus.adc_start, 0);
    checkOutput("rstAdcCh", bus.adc_ch, 0);
    checkOutput("rstAck", bus.ack, 0);
    checkOutput("rstResData", bus.res_data, 0);
    checkOutput("rstResCh", bus.res_ch, 0);
    checkOutput("rstResErr", bus.res_err, 0);
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int c = 1; c <= 5 && !got; c++) begin
      @(negedge clk);
      if (bus.adc_start) got = 1;
    end
    checkOutput("postRstStart", got, 1);
    checkOutput("postRstGrant", bus.adc_ch, 0);
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      if (bus.res_valid) got = 1;
      else if (c == 2) begin
        bus.adc_done = 1'b1;
        bus.adc_data = 12'h3A7;
      end
    end
    checkOutput("postRstValid", got, 1);
    checkOutput("postRstData", bus.res_data, 12'h3A7);
    bus.res_ready = 1'b1;
    #1;
    checkOutput("postRstAck", bus.ack, 4'b0001);
    bus.req = '0;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

`ifdef SAR_SCAN_AVG_EN
  // Four passes on channel 0: 100+101+102+105 = 408, mean 102.
  task automatic runAverage();
    int   samples[4] = '{100, 101, 102, 105};
    int   starts;
    int   doneAt;
    bit   got;
    bit   chOk;
    @(negedge clk);
    bus.req = 4'b0001;
    starts = 0; doneAt = -1; got = 0; chOk = 1;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      bus.adc_done = 1'b0;
      if (bus.res_valid) got = 1;
      else begin
        if (bus.adc_start) begin
          starts++;
          doneAt = c + 3;
          if (bus.adc_ch !== 2'd0) chOk = 0;
        end
        if (c == doneAt && starts >= 1 && starts <= 4) begin
          bus.adc_done = 1'b1;
          bus.adc_data = 12'(samples[starts-1]);
        end
      end
    end
    checkOutput("avgValid", got, 1);
    checkOutput("avgStarts", starts, 4);
    checkOutput("avgCh", chOk, 1);
    checkOutput("avgData", bus.res_data, 102);
    checkOutput("avgErr", bus.res_err, 0);
    bus.res_ready = 1'b1;
    #1;
    checkOutput("avgAck", bus.ack, 4'b0001);
    bus.req = '0;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.req       = '0;
    bus.adc_done  = 1'b0;
    bus.adc_data  = '0;
    bus.res_ready = 1'b0;

    // Pointer evolution: 0 -> 3 -> 1 -> 0 -> 2 -> 1 -> 2 -> 3 -> 0.
    vecs[0] = '{req:4'b0100, doneDly:14, data:12'hA5C, readyDly:0,  readyEarly:0, dropReq:0, expCh:2'd2, expData:12'hA5C, expErr:0, expLat:15, expAck:4'b0100};
    vecs[1] = '{req:4'b0011, doneDly:3,  data:12'h123, readyDly:10, readyEarly:0, dropReq:0, expCh:2'd0, expData:12'h123, expErr:0, expLat:4,  expAck:4'b0001};
    vecs[2] = '{req:4'b1001, doneDly:0,  data:12'h555, readyDly:2,  readyEarly:0, dropReq:0, expCh:2'd3, expData:12'h000, expErr:1, expLat:65, expAck:4'b1000};
    vecs[3] = '{req:4'b0010, doneDly:64, data:12'hFFF, readyDly:0,  readyEarly:1, dropReq:0, expCh:2'd1, expData:12'hFFF, expErr:0, expLat:65, expAck:4'b0010};
    vecs[4] = '{req:4'b0001, doneDly:1,  data:12'h800, readyDly:0,  readyEarly:0, dropReq:1, expCh:2'd0, expData:12'h800, expErr:0, expLat:2,  expAck:4'b0001};
    vecs[5] = '{req:4'b1110, doneDly:65, data:12'h7FF, readyDly:1,  readyEarly:0, dropReq:0, expCh:2'd1, expData:12'h000, expErr:1, expLat:65, expAck:4'b0010};
    vecs[6] = '{req:4'b1100, doneDly:2,  data:12'h3C3, readyDly:0,  readyEarly:1, dropReq:0, expCh:2'd2, expData:12'h3C3, expErr:0, expLat:3,  expAck:4'b0100};
    vecs[7] = '{req:4'b1000, doneDly:5,  data:12'h001, readyDly:3,  readyEarly:0, dropReq:0, expCh:2'd3, expData:12'h001, expErr:0, expLat:6,  expAck:4'b1000};

    @(negedge clk);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetValid", bus.res_valid, 0);
    checkOutput("resetStart", bus.adc_start, 0);
    checkOutput("resetAdcCh", bus.adc_ch, 0);
    checkOutput("resetAck", bus.ack, 0);
    checkOutput("resetData", bus.res_data, 0);
    checkOutput("resetErr", bus.res_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SAR_SCAN_AVG_EN
    runAverage();
`else
    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end
    runRoundRobin();
    runResetMidWait();
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
